// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with start/done framing, optional care mask (PAT_MASK_EN)
module seq_detector_param #(
    parameter int PAT_W     = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic [PAT_W-1:0]     pattern,
`ifdef PAT_MASK_EN
    input  logic [PAT_W-1:0]     care_mask,
`endif
    output logic                 busy,
    output logic                 match,
    output logic [FRAME_LEN-1:0] hit_map,
    output logic [CNT_W-1:0]     hit_count,
    output logic                 frame_done,
    output logic [PAT_W-1:0]     window
);

    // Index counts up to FRAME_LEN after the last bit, so it needs one extra code.
    localparam int                   IDX_W    = $clog2(FRAME_LEN + 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]     FILL_IDX = IDX_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [FRAME_LEN-1:0] MAP_LSB  = FRAME_LEN'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PAT_W-1:0]     window_q, window_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PAT_W-1:0]     pat_q, pat_d;
    logic [PAT_W-1:0]     mask_q;
    logic [FRAME_LEN-1:0] hit_map_q, hit_map_d;
    logic [CNT_W-1:0]     hit_count_q, hit_count_d;
    logic                 match_q, match_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic [PAT_W-1:0]     shifted;
    logic                 hit;

    // A start is only honoured between frames; RUN ignores it.
    assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // Window as it would look once the current din is shifted in.
    assign shifted = {window_q[PAT_W-2:0], din};
    // Compare is gated until a full window of this frame's bits has been seen.
    assign hit     = (((shifted ^ pat_q) & mask_q) == '0) && (idx_q >= FILL_IDX);

`ifdef PAT_MASK_EN
    // Care mask is captured together with the pattern on an accepted start
    always_ff @(posedge clk) begin
        if (Reset) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= care_mask;
        end
    end
`else
    assign mask_q = '1;
`endif

    // Next-state and datapath updates for IDLE/RUN/DONE
    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        idx_d       = idx_q;
        pat_d       = pat_q;
        hit_map_d   = hit_map_q;
        hit_count_d = hit_count_q;
        match_d     = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d     = ST_RUN;
                    window_d    = '0;
                    idx_d       = '0;
                    hit_map_d   = '0;
                    hit_count_d = '0;
                    pat_d       = pattern;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (din_valid) begin
                    window_d = shifted;
                    idx_d    = idx_q + 1'b1;
                    if (hit) begin
                        match_d   = 1'b1;
                        hit_map_d = hit_map_q | (MAP_LSB << (LAST_IDX - idx_q));
                        if (hit_count_q != CNT_MAX) begin
                            hit_count_d = hit_count_q + 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            window_q    <= '0;
            idx_q       <= '0;
            pat_q       <= '0;
            hit_map_q   <= '0;
            hit_count_q <= '0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            idx_q       <= idx_d;
            pat_q       <= pat_d;
            hit_map_q   <= hit_map_d;
            hit_count_q <= hit_count_d;
            match_q     <= match_d;
            done_q      <= done_d;
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign match      = match_q;
    assign frame_done = done_q;
    assign hit_map    = hit_map_q;
    assign hit_count  = hit_count_q;
    assign window     = window_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - randomized self-checking bench for seq_detector_param
module tb_seq_detector_param;

    localparam int PAT_W     = 4;
    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = 4;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 Reset;
    logic                 start;
    logic                 din;
    logic                 din_valid;
    logic [PAT_W-1:0]     pattern;
    logic [PAT_W-1:0]     care_mask;
    logic                 busy;
    logic                 match;
    logic [FRAME_LEN-1:0] hit_map;
    logic [CNT_W-1:0]     hit_count;
    logic                 frame_done;
    logic [PAT_W-1:0]     window;

    // Second instance: tiny counter to reach saturation
    logic                 s_start;
    logic                 s_din;
    logic                 s_valid;
    logic [1:0]           s_pattern;
    logic [1:0]           s_care;
    logic                 s_busy;
    logic                 s_match;
    logic [19:0]          s_hit_map;
    logic [2:0]           s_hit_count;
    logic                 s_frame_done;
    logic [1:0]           s_window;

    seq_detector_param #(.PAT_W(PAT_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .Reset      (Reset),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .pattern    (pattern),
`ifdef PAT_MASK_EN
        .care_mask  (care_mask),
`endif
        .busy       (busy),
        .match      (match),
        .hit_map    (hit_map),
        .hit_count  (hit_count),
        .frame_done (frame_done),
        .window     (window)
    );

    seq_detector_param #(.PAT_W(2), .FRAME_LEN(20), .CNT_W(3)) u_sat (
        .clk        (clk),
        .Reset      (Reset),
        .start      (s_start),
        .din        (s_din),
        .din_valid  (s_valid),
        .pattern    (s_pattern),
`ifdef PAT_MASK_EN
        .care_mask  (s_care),
`endif
        .busy       (s_busy),
        .match      (s_match),
        .hit_map    (s_hit_map),
        .hit_count  (s_hit_count),
        .frame_done (s_frame_done),
        .window     (s_window)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state for the current frame
    logic [PAT_W-1:0]     m_pat;
    logic [PAT_W-1:0]     m_mask;
    logic [FRAME_LEN-1:0] m_map;
    int                   m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic d);
        start     = s;
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [PAT_W-1:0] pat, input logic [PAT_W-1:0] msk);
        pattern   = pat;
        care_mask = msk;
        step(1'b1, 1'b1, 1'($urandom));
        m_pat = pat;
`ifdef PAT_MASK_EN
        m_mask = msk;
`else
        m_mask = '1;
`endif
        m_map = '0;
        m_cnt = 0;
        check("start_busy", busy, 1);
        check("start_window", window, 0);
        check("start_map", hit_map, 0);
        check("start_count", hit_count, 0);
        check("start_match", match, 0);
        check("start_done", frame_done, 0);
    endtask

    // Feeds the first nbits bits of stream (MSB = frame bit 0) with random gaps
    task automatic feed(input logic [FRAME_LEN-1:0] stream, input int nbits,
                        input int min_gap, input int max_gap);
        for (int k = 0; k < nbits; k++) begin
            int               gaps;
            logic [PAT_W-1:0] win;
            logic             exp_hit;
            gaps = int'($urandom_range(max_gap, min_gap));
            for (int g = 0; g < gaps; g++) begin
                pattern   = PAT_W'($urandom);
                care_mask = PAT_W'($urandom);
                step(1'($urandom), 1'b0, 1'($urandom));
                check("gap_match", match, 0);
                check("gap_busy", busy, 1);
            end
            pattern   = PAT_W'($urandom);
            care_mask = PAT_W'($urandom);
            step(1'($urandom), 1'b1, stream[FRAME_LEN-1-k]);
            win     = PAT_W'(64'(stream) >> (FRAME_LEN - 1 - k));
            exp_hit = (k >= PAT_W - 1) && (((win ^ m_pat) & m_mask) == '0);
            if (exp_hit) begin
                m_map[FRAME_LEN-1-k] = 1'b1;
                if (m_cnt < CNT_SAT) m_cnt++;
            end
            check("bit_match", match, exp_hit);
            check("bit_window", window, win);
            check("bit_map", hit_map, m_map);
            check("bit_count", hit_count, m_cnt);
            check("bit_busy", busy, k != FRAME_LEN - 1);
            check("bit_done", frame_done, k == FRAME_LEN - 1);
        end
    endtask

    task automatic idle_check();
        step(1'b0, 1'($urandom), 1'($urandom));
        check("idle_busy", busy, 0);
        check("idle_done", frame_done, 0);
        check("idle_match", match, 0);
        check("idle_map", hit_map, m_map);
        check("idle_count", hit_count, m_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FRAME_LEN-1:0] stream;
        logic [PAT_W-1:0]     pat;
        logic [PAT_W-1:0]     msk;

        Reset = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0;
        pattern = '0; care_mask = '1;
        s_start = 1'b0; s_din = 1'b0; s_valid = 1'b0; s_pattern = 2'b11; s_care = 2'b11;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("rst_busy", busy, 0);
        check("rst_match", match, 0);
        check("rst_done", frame_done, 0);
        check("rst_map", hit_map, 0);
        check("rst_count", hit_count, 0);
        check("rst_window", window, 0);
        Reset = 1'b0;

        // Overlapping hits
        start_frame(4'b1011, 4'b1111);
        feed(8'b1011_0110, FRAME_LEN, 0, 0);
        check("ovl_map", hit_map, 8'b0001_0010);
        check("ovl_count", hit_count, 2);
        idle_check();

        // Fill gating with an all-zero pattern
        start_frame(4'b0000, 4'b1111);
        feed(8'b0000_0000, FRAME_LEN, 0, 0);
        check("fill_map", hit_map, 8'b0001_1111);
        check("fill_count", hit_count, 5);
        idle_check();

        // Three-cycle gaps between every bit
        start_frame(4'b1011, 4'b1111);
        feed(8'b1011_0110, FRAME_LEN, 3, 3);
        check("gap3_map", hit_map, 8'b0001_0010);
        check("gap3_count", hit_count, 2);
        idle_check();

        // Reset in the middle of a frame
        start_frame(4'b1011, 4'b1111);
        feed(8'b1011_0110, 5, 0, 1);
        Reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        Reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_match", match, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_map", hit_map, 0);
        check("mid_rst_count", hit_count, 0);
        check("mid_rst_window", window, 0);
        m_map = '0;
        m_cnt = 0;
        idle_check();
        start_frame(4'b1011, 4'b1111);
        feed(8'b1011_0110, FRAME_LEN, 0, 0);
        check("post_rst_map", hit_map, 8'b0001_0010);

        // Back-to-back: start taken in the DONE cycle
        start_frame(4'b1111, 4'b1111);
        feed(8'b1111_1111, FRAME_LEN, 0, 0);
        check("b2b_map", hit_map, 8'b0001_1111);
        check("b2b_count", hit_count, 5);
        idle_check();

`ifdef PAT_MASK_EN
        start_frame(4'b1001, 4'b1001);
        feed(8'b1111_1001, FRAME_LEN, 0, 0);
        check("mask_map", hit_map, 8'b0001_1001);
        check("mask_count", hit_count, 3);
        idle_check();
        start_frame(4'b0110, 4'b0000);
        feed(8'b1010_0011, FRAME_LEN, 0, 0);
        check("mask0_map", hit_map, 8'b0001_1111);
        check("mask0_count", hit_count, 5);
        idle_check();
`endif

        // Randomized frames, some back-to-back
        for (int f = 0; f < 150; f++) begin
            pat = PAT_W'($urandom);
            msk = PAT_W'($urandom);
            if ($urandom_range(3, 0) == 0) msk = '1;
            if ($urandom_range(1, 0) == 0) begin
                stream = FRAME_LEN'($urandom);
            end else begin
                for (int i = 0; i < FRAME_LEN; i++) begin
                    stream[i] = pat[i % PAT_W] ^ ($urandom_range(5, 0) == 0);
                end
            end
            start_frame(pat, msk);
            feed(stream, FRAME_LEN, 0, int'($urandom_range(2, 0)));
            if ($urandom_range(1, 0) == 0) idle_check();
        end
        idle_check();

        // Saturating counter: 19 overlapping hits into a 3-bit count
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        check("sat_busy", s_busy, 1);
        for (int k = 0; k < 20; k++) begin
            s_valid = 1'b1;
            s_din   = 1'b1;
            @(posedge clk); #1;
            check("sat_match", s_match, k >= 1);
            check("sat_count", s_hit_count, (k < 7) ? k : 7);
        end
        s_valid = 1'b0;
        check("sat_done", s_frame_done, 1);
        check("sat_map", s_hit_map, 20'h7FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector. It accepts one serial bit per valid cycle over a frame of FRAME_LEN bits and slides a PAT_W-bit window across the stream. Every bit position where the window equals the programmed pattern is flagged, including overlapping occurrences. It replaces the fixed 4-bit / 8-position detector with a start/done handshake, fill gating, a hit count and a back-to-back frame mode.

Parameters:
PAT_W, 4, pattern and window width in bits (2..16)
FRAME_LEN, 8, serial bits per frame = number of hit_map positions (>= PAT_W)
CNT_W, 4, hit_count width; saturates at 2^CNT_W-1

Ports:
clk  in  1  clock, all logic on rising edge
Reset  in  1  synchronous active-high reset
start  in  1  begin a frame; sampled in IDLE and DONE only
din  in  1  serial data bit
din_valid  in  1  din qualifier; one bit consumed per cycle high in RUN
pattern  in  PAT_W  target pattern, MSB = oldest bit; latched on accepted start
busy  out  1  high in RUN
match  out  1  one-cycle pulse: window matched on last consumed bit
hit_map  out  FRAME_LEN  bit [FRAME_LEN-1-k] set if match completed at frame bit k (k=0 first)
hit_count  out  CNT_W  matches in current/last frame, saturating
frame_done  out  1  one-cycle pulse after FRAME_LEN-th bit consumed
window  out  PAT_W  current shift window (debug)

Behaviour:
- Reset (synchronous, Reset=1 at clk edge): state=IDLE; busy, match, frame_done=0; hit_map, hit_count, window, bit index, latched pattern = 0. Reset mid-frame aborts the frame, no frame_done.
- FSM states IDLE, RUN, DONE.
- IDLE: start=1 -> RUN; clears window, hit_map, hit_count, bit index; latches pattern. din_valid in the start cycle is ignored.
- RUN: each din_valid=1 cycle: window <= {window[PAT_W-2:0], din}; bit index k increments. Gaps (din_valid=0) hold all state, match=0.
- Fill gating: a compare is valid only when k >= PAT_W-1, meaning at least PAT_W bits have been consumed in this frame. Earlier bits never flag, even if the zeroed window happens to equal the pattern.
- On a valid compare equal to the latched pattern:
  - match=1 in the next cycle (latency 1 from the din edge).
  - hit_map[FRAME_LEN-1-k] set in the same cycle as match.
  - hit_count increments, saturating.
- After bit k=FRAME_LEN-1 is consumed -> DONE. frame_done=1 and busy=0 for exactly one cycle.
- DONE: lasts one cycle.
  - start=1 -> RUN directly, with the same clearing as from IDLE (back-to-back frames with no gap).
  - Otherwise -> IDLE.
- hit_map and hit_count hold their final values in IDLE until the next accepted start.
- start while in RUN is ignored. Changes to pattern mid-frame are ignored.
- Overlapping matches all count. Example: pattern 1011 with stream 1011011 hits at k=3 and k=6.
- match may coincide with frame_done when the last bit completes a match.

Optional Feature:
PAT_MASK_EN: when defined, adds input care_mask [PAT_W], latched with pattern on accepted start. The compare becomes ((window ^ pattern) & care_mask) == 0; a mask bit of 0 means don't-care. All-zero mask matches at every gated position. When undefined, the port is absent and an exact compare is used.

Test Plan:
- PAT_W=4, FRAME_LEN=8, pattern=4'b1011, start, then bits 1,0,1,1,0,1,1,0 on consecutive cycles -> match pulses after bits 3 and 6, hit_map=8'b0001_0010, hit_count=2, frame_done one cycle after bit 7.
- pattern=4'b0000, eight 0 bits -> no match for k=0..2, hit_map=8'b0001_1111, hit_count=5 (fill gating).
- pattern=4'b1011 stream as in first scenario, with din_valid low for 3 cycles between each bit -> same hit_map/hit_count, match only on valid+1 cycles.
- Reset asserted after 5 bits of a frame -> next cycle all outputs 0, state IDLE, no frame_done; a new frame then runs clean.
- start held high through DONE with a second frame of eight 1s, pattern 4'b1111 -> second frame starts with no idle cycle, hit_map=8'b0001_1111, hit_count=5.
- PAT_MASK_EN defined, pattern=4'b1001, care_mask=4'b1001, stream 1,1,1,1,1,0,0,1 -> hits at k=3,4,7: hit_map=8'b0001_1001, hit_count=3.
